l1_dcache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache between the CPU memory stage and the L1 MMU.
- Serves word reads and word/half/byte writes in zero wait cycles on a hit.
- On a miss: stalls the pipeline, writes back a dirty victim line, refills the 256-bit line from the MMU.

---
 rtl/l1_dcache_wb_if.sv | 34 +++
 rtl/l1_dcache_wb.sv | 238 +++++++++++++++++++++++
 tb/tb_l1_dcache_wb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_dcache_wb_if.sv
// CPU-side and MMU-side signal bundle for l1_dcache_wb.
// master = pipeline/MMU environment, slave = the cache.
interface l1_dcache_wb_if;
  // CPU memory stage
  logic         l1_read;
  logic         l1_write;
  logic [31:0]  l1_addr;
  logic [1:0]   l1_write_type;
  logic [31:0]  l1_write_data;
  logic [31:0]  l1_data_o;
  logic         stall;
  // L1 MMU
  logic         l1_mmu_req_read;
  logic         l1_mmu_req_write;
  logic [31:0]  l1_mmu_req_addr;
  logic [255:0] l1_mmu_write_data;
  logic         mmu_l1_read_done;
  logic         mmu_l1_write_done;
  logic [255:0] mmu_l1_read_data;

  modport master (
    output l1_read, l1_write, l1_addr, l1_write_type, l1_write_data,
    output mmu_l1_read_done, mmu_l1_write_done, mmu_l1_read_data,
    input  l1_data_o, stall,
    input  l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data
  );

  modport slave (
    input  l1_read, l1_write, l1_addr, l1_write_type, l1_write_data,
    input  mmu_l1_read_done, mmu_l1_write_done, mmu_l1_read_data,
    output l1_data_o, stall,
    output l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data
  );
endinterface

// File: rtl/l1_dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Define L1_UNCACHED_EN to make accesses with addr[31:28] == 4'hF bypass the cache.
module l1_dcache_wb #(
  parameter int unsigned INDEX_BITS = 6
) (
  input logic           sys_clk,
  input logic           rst_n,
  l1_dcache_wb_if.slave bus
);

  localparam int unsigned NumLines = 1 << INDEX_BITS;
  localparam int unsigned TagBits  = 27 - INDEX_BITS;

`ifdef L1_UNCACHED_EN
  typedef enum logic [2:0] {StIdle, StWb, StFill, StUcRd, StUcWr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;
`endif

  state_e state_q, state_d;

  logic [255:0]        data_q [NumLines];
  logic [TagBits-1:0]  tag_q  [NumLines];
  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;

  // Miss context is latched so a request dropped mid-miss still completes cleanly.
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [26:0]           fill_line_q, fill_line_d;

`ifdef L1_UNCACHED_EN
  logic [29:0] uc_addr_q, uc_addr_d;
  logic [31:0] uc_wdata_q, uc_wdata_d;
`endif

  logic [INDEX_BITS-1:0] idx;
  logic [TagBits-1:0]    tag;
  logic [2:0]            word_sel;
  logic [7:0]            word_off;
  logic                  req;
  logic                  is_write;
  logic                  uc_access;
  logic                  hit;

  assign idx      = bus.l1_addr[INDEX_BITS+4:5];
  assign tag      = bus.l1_addr[31:INDEX_BITS+5];
  assign word_sel = bus.l1_addr[4:2];
  assign word_off = {word_sel, 5'b00000};
  assign req      = bus.l1_read | bus.l1_write;
  assign is_write = bus.l1_write;

`ifdef L1_UNCACHED_EN
  assign uc_access = (bus.l1_addr[31:28] == 4'hF);
`else
  assign uc_access = 1'b0;
`endif

  assign hit = valid_q[idx] && (tag_q[idx] == tag) && !uc_access;

  // Store lanes: data is replicated across lanes and st_be picks the bytes to update.
  logic [3:0]  st_be;
  logic [31:0] st_word;
  logic [31:0] old_word;
  logic [31:0] merged_word;
  logic [31:0] masked_word;
  logic [255:0] hit_line;

  always_comb begin
    st_be   = 4'b1111;
    st_word = bus.l1_write_data;
    case (bus.l1_write_type)
      2'b01: begin
        st_be   = bus.l1_addr[1] ? 4'b1100 : 4'b0011;
        st_word = {2{bus.l1_write_data[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b0001 << bus.l1_addr[1:0];
        st_word = {4{bus.l1_write_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign old_word = data_q[idx][word_off +: 32];

  always_comb begin
    merged_word = '0;
    masked_word = '0;
    for (int b = 0; b < 4; b++) begin
      merged_word[8*b +: 8] = st_be[b] ? st_word[8*b +: 8] : old_word[8*b +: 8];
      masked_word[8*b +: 8] = st_be[b] ? st_word[8*b +: 8] : 8'h00;
    end
  end

  always_comb begin
    hit_line = data_q[idx];
    hit_line[word_off +: 32] = merged_word;
  end

  logic write_hit;
  logic wb_done;
  logic fill_done;

  always_comb begin
    state_d                = state_q;
    miss_idx_d             = miss_idx_q;
    fill_line_d            = fill_line_q;
`ifdef L1_UNCACHED_EN
    uc_addr_d              = uc_addr_q;
    uc_wdata_d             = uc_wdata_q;
`endif
    bus.stall              = 1'b0;
    bus.l1_data_o          = '0;
    bus.l1_mmu_req_read    = 1'b0;
    bus.l1_mmu_req_write   = 1'b0;
    bus.l1_mmu_req_addr    = '0;
    bus.l1_mmu_write_data  = '0;
    write_hit              = 1'b0;
    wb_done                = 1'b0;
    fill_done              = 1'b0;

    case (state_q)
      StIdle: begin
        if (req) begin
          if (uc_access) begin
`ifdef L1_UNCACHED_EN
            bus.stall  = 1'b1;
            uc_addr_d  = bus.l1_addr[31:2];
            uc_wdata_d = masked_word;
            state_d    = is_write ? StUcWr : StUcRd;
`endif
          end else if (hit) begin
            if (is_write) begin
              write_hit = 1'b1;
            end else begin
              bus.l1_data_o = old_word;
            end
          end else begin
            bus.stall   = 1'b1;
            miss_idx_d  = idx;
            fill_line_d = bus.l1_addr[31:5];
            state_d     = (valid_q[idx] && dirty_q[idx]) ? StWb : StFill;
          end
        end
      end

      StWb: begin
        bus.stall             = 1'b1;
        bus.l1_mmu_req_write  = 1'b1;
        bus.l1_mmu_req_addr   = {tag_q[miss_idx_q], miss_idx_q, 5'b00000};
        bus.l1_mmu_write_data = data_q[miss_idx_q];
        if (bus.mmu_l1_write_done) begin
          wb_done = 1'b1;
          state_d = StFill;
        end
      end

      StFill: begin
        bus.stall           = 1'b1;
        bus.l1_mmu_req_read = 1'b1;
        bus.l1_mmu_req_addr = {fill_line_q, 5'b00000};
        if (bus.mmu_l1_read_done) begin
          fill_done = 1'b1;
          state_d   = StIdle;
        end
      end

`ifdef L1_UNCACHED_EN
      // Stall drops in the done cycle so the pipeline retires the access exactly once.
      StUcRd: begin
        bus.stall           = !bus.mmu_l1_read_done;
        bus.l1_mmu_req_read = 1'b1;
        bus.l1_mmu_req_addr = {uc_addr_q, 2'b00};
        if (bus.mmu_l1_read_done) begin
          bus.l1_data_o = bus.mmu_l1_read_data[31:0];
          state_d       = StIdle;
        end
      end

      StUcWr: begin
        bus.stall             = !bus.mmu_l1_write_done;
        bus.l1_mmu_req_write  = 1'b1;
        bus.l1_mmu_req_addr   = {uc_addr_q, 2'b00};
        bus.l1_mmu_write_data = {224'd0, uc_wdata_q};
        if (bus.mmu_l1_write_done) begin
          state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_idx_q  <= '0;
      fill_line_q <= '0;
`ifdef L1_UNCACHED_EN
      uc_addr_q   <= '0;
      uc_wdata_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      miss_idx_q  <= miss_idx_d;
      fill_line_q <= fill_line_d;
`ifdef L1_UNCACHED_EN
      uc_addr_q   <= uc_addr_d;
      uc_wdata_q  <= uc_wdata_d;
`endif
      if (write_hit) begin
        dirty_q[idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Line storage carries no reset; valid_q guards every use.
  always_ff @(posedge sys_clk) begin
    if (write_hit) begin
      data_q[idx] <= hit_line;
    end
    if (fill_done) begin
      data_q[miss_idx_q] <= bus.mmu_l1_read_data;
      tag_q[miss_idx_q]  <= fill_line_q[26:INDEX_BITS];
    end
  end

endmodule

// File: tb/tb_l1_dcache_wb.sv
// Directed bench for l1_dcache_wb: hit vectors from a table, miss/write-back/reset
// sequences written out by hand with a small in-bench MMU responder.
module tb_l1_dcache_wb;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  l1_dcache_wb_if bus ();

  l1_dcache_wb #(.INDEX_BITS(6)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  wt;
    logic [31:0] wd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [1:0] wt, input logic [31:0] wd);
    bus.l1_read       = rd;
    bus.l1_write      = wr;
    bus.l1_addr       = addr;
    bus.l1_write_type = wt;
    bus.l1_write_data = wd;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
    return l;
  endfunction

  // Waits (bounded) for a refill request, checks it, returns one read_done pulse.
  task automatic serve_read(input string name, input logic [31:0] exp_addr,
                            input logic [255:0] line, output int waits);
    waits = 0;
    @(negedge sys_clk);
    while (!bus.l1_mmu_req_read && waits < 20) begin
      @(negedge sys_clk);
      waits++;
    end
    check({name, "_req_read"}, 256'(bus.l1_mmu_req_read), 256'(1'b1));
    check({name, "_no_req_write"}, 256'(bus.l1_mmu_req_write), 256'(1'b0));
    check({name, "_fill_addr"}, 256'(bus.l1_mmu_req_addr), 256'(exp_addr));
    bus.mmu_l1_read_done = 1'b1;
    bus.mmu_l1_read_data = line;
    tick();
    bus.mmu_l1_read_done = 1'b0;
    bus.mmu_l1_read_data = '0;
  endtask

  task automatic serve_write(input string name, input logic [31:0] exp_addr,
                             input logic [255:0] exp_line, output int waits);
    waits = 0;
    @(negedge sys_clk);
    while (!bus.l1_mmu_req_write && waits < 20) begin
      @(negedge sys_clk);
      waits++;
    end
    check({name, "_req_write"}, 256'(bus.l1_mmu_req_write), 256'(1'b1));
    check({name, "_no_req_read"}, 256'(bus.l1_mmu_req_read), 256'(1'b0));
    check({name, "_wb_addr"}, 256'(bus.l1_mmu_req_addr), 256'(exp_addr));
    check({name, "_wb_data"}, bus.l1_mmu_write_data, exp_line);
    bus.mmu_l1_write_done = 1'b1;
    tick();
    bus.mmu_l1_write_done = 1'b0;
  endtask

  logic [255:0] line1, line2, line3, exp_line;
  logic [31:0]  wvals [8];
  int           waits;

  initial begin
    wvals = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888,
              32'h9999AAAA, 32'hBBBBCCCC, 32'hDDDDEEEE, 32'hFFFF0000};
    line1 = mk_line(32'h1000_0000);
    line1[96 +: 32] = 32'h12345678;
    line2 = mk_line(32'h2000_0000);
    line3 = mk_line(32'h3000_0000);

    // Hit vectors on line 0x00010000 (filled with line3 first).
    for (int i = 0; i < 8; i++) vq.push_back('{1'b0, 1'b1, 32'h10000 + 4 * i, 2'd0, wvals[i], 32'h0});
    for (int i = 0; i < 8; i++) vq.push_back('{1'b1, 1'b0, 32'h10000 + 4 * i, 2'd0, 32'h0, wvals[i]});
    vq.push_back('{1'b0, 1'b1, 32'h10000, 2'd1, 32'hFFFF1234, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10000, 2'd0, 32'h0, 32'h11111234});
    vq.push_back('{1'b0, 1'b1, 32'h10002, 2'd1, 32'h00001234, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10000, 2'd0, 32'h0, 32'h12341234});
    vq.push_back('{1'b0, 1'b1, 32'h10008, 2'd2, 32'h123456FF, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10008, 2'd0, 32'h0, 32'h555566FF});
    vq.push_back('{1'b0, 1'b1, 32'h10009, 2'd2, 32'h000000FF, 32'h0});
    vq.push_back('{1'b0, 1'b1, 32'h1000A, 2'd2, 32'h000000FF, 32'h0});
    vq.push_back('{1'b0, 1'b1, 32'h1000B, 2'd2, 32'h000000FF, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10008, 2'd0, 32'h0, 32'hFFFFFFFF});
    vq.push_back('{1'b0, 1'b1, 32'h10006, 2'd3, 32'hCAFEF00D, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10004, 2'd0, 32'h0, 32'hCAFEF00D});
    vq.push_back('{1'b0, 1'b1, 32'h1000D, 2'd1, 32'h0000BEEF, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h1000C, 2'd0, 32'h0, 32'h7777BEEF});
    vq.push_back('{1'b1, 1'b1, 32'h10010, 2'd0, 32'h0D0D0D0D, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10010, 2'd0, 32'h0, 32'h0D0D0D0D});
    vq.push_back('{1'b0, 1'b0, 32'h10010, 2'd0, 32'h0, 32'h0});

    drive(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    bus.mmu_l1_read_done  = 1'b0;
    bus.mmu_l1_write_done = 1'b0;
    bus.mmu_l1_read_data  = '0;

    // Reset state
    repeat (3) tick();
    @(negedge sys_clk);
    check("rst_stall", 256'(bus.stall), 256'(1'b0));
    check("rst_req_read", 256'(bus.l1_mmu_req_read), 256'(1'b0));
    check("rst_req_write", 256'(bus.l1_mmu_req_write), 256'(1'b0));
    check("rst_req_addr", 256'(bus.l1_mmu_req_addr), 256'(32'h0));
    check("rst_write_data", bus.l1_mmu_write_data, 256'(0));
    check("rst_data_o", 256'(bus.l1_data_o), 256'(32'h0));

    // 1: cold read miss, refill, then hit
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0000800C, 2'd0, 32'h0);
    @(negedge sys_clk);
    check("t1_miss_stall", 256'(bus.stall), 256'(1'b1));
    check("t1_miss_data_o", 256'(bus.l1_data_o), 256'(32'h0));
    serve_read("t1", 32'h00008000, line1, waits);
    check("t1_clean_victim_no_wb", 256'(waits), 256'(0));
    @(negedge sys_clk);
    check("t1_hit_stall", 256'(bus.stall), 256'(1'b0));
    check("t1_hit_data", 256'(bus.l1_data_o), 256'(32'h12345678));

    // 2: write hit, read back
    tick();
    drive(1'b0, 1'b1, 32'h0000800C, 2'd0, 32'hAAAABBBB);
    @(negedge sys_clk);
    check("t2_wr_stall", 256'(bus.stall), 256'(1'b0));
    check("t2_wr_no_req", 256'(bus.l1_mmu_req_write | bus.l1_mmu_req_read), 256'(1'b0));
    tick();
    drive(1'b1, 1'b0, 32'h0000800C, 2'd0, 32'h0);
    @(negedge sys_clk);
    check("t2_rd_data", 256'(bus.l1_data_o), 256'(32'hAAAABBBB));
    check("t2_rd_no_req", 256'(bus.l1_mmu_req_read), 256'(1'b0));

    // 3: conflict write miss with dirty victim
    tick();
    drive(1'b0, 1'b1, 32'h0001800C, 2'd0, 32'hBBB00CCC);
    @(negedge sys_clk);
    check("t3_miss_stall", 256'(bus.stall), 256'(1'b1));
    exp_line = line1;
    exp_line[96 +: 32] = 32'hAAAABBBB;
    serve_write("t3", 32'h00008000, exp_line, waits);
    serve_read("t3", 32'h00018000, line2, waits);
    check("t3_fill_follows_wb", 256'(waits), 256'(0));
    @(negedge sys_clk);
    check("t3_post_fill_stall", 256'(bus.stall), 256'(1'b0));
    tick();
    drive(1'b1, 1'b0, 32'h0001800C, 2'd0, 32'h0);
    @(negedge sys_clk);
    check("t3_store_landed", 256'(bus.l1_data_o), 256'(32'hBBB00CCC));
    tick();
    drive(1'b1, 1'b0, 32'h0000800C, 2'd0, 32'h0);
    @(negedge sys_clk);
    check("t3_dirty_evict_stall", 256'(bus.stall), 256'(1'b1));
    exp_line = line2;
    exp_line[96 +: 32] = 32'hBBB00CCC;
    serve_write("t3_dirty", 32'h00018000, exp_line, waits);
    serve_read("t3_refill", 32'h00008000, line1, waits);
    @(negedge sys_clk);
    check("t3_refill_data", 256'(bus.l1_data_o), 256'(32'h12345678));

    // 4/5: fill 0x00010000 (clean victim), then table of hit accesses
    tick();
    drive(1'b1, 1'b0, 32'h00010000, 2'd0, 32'h0);
    @(negedge sys_clk);
    check("t4_miss_stall", 256'(bus.stall), 256'(1'b1));
    serve_read("t4", 32'h00010000, line3, waits);
    check("t4_clean_victim_no_wb", 256'(waits), 256'(0));
    @(negedge sys_clk);
    check("t4_fill_data", 256'(bus.l1_data_o), 256'(32'h30000000));
    foreach (vq[i]) begin
      tick();
      drive(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wt, vq[i].wd);
      @(negedge sys_clk);
      check($sformatf("vec%0d_stall", i), 256'(bus.stall), 256'(1'b0));
      check($sformatf("vec%0d_data", i), 256'(bus.l1_data_o), 256'(vq[i].exp_data));
      check($sformatf("vec%0d_no_req", i),
            256'(bus.l1_mmu_req_read | bus.l1_mmu_req_write), 256'(1'b0));
    end

    // 6: reset during write-back aborts it; line is invalid afterwards
    tick();
    drive(1'b1, 1'b0, 32'h00008000, 2'd0, 32'h0);
    waits = 0;
    @(negedge sys_clk);
    while (!bus.l1_mmu_req_write && waits < 20) begin
      @(negedge sys_clk);
      waits++;
    end
    check("t6_wb_started", 256'(bus.l1_mmu_req_write), 256'(1'b1));
    check("t6_wb_addr", 256'(bus.l1_mmu_req_addr), 256'(32'h00010000));
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    tick();
    @(negedge sys_clk);
    check("t6_rst_req_write", 256'(bus.l1_mmu_req_write), 256'(1'b0));
    check("t6_rst_stall", 256'(bus.stall), 256'(1'b0));
    rst_n = 1'b1;
    bus.mmu_l1_write_done = 1'b1;
    tick();
    bus.mmu_l1_write_done = 1'b0;
    @(negedge sys_clk);
    check("t6_late_done_ignored", 256'({bus.l1_mmu_req_read, bus.l1_mmu_req_write, bus.stall}),
          256'(3'b000));
    tick();
    drive(1'b1, 1'b0, 32'h00010000, 2'd0, 32'h0);
    @(negedge sys_clk);
    check("t6_invalid_miss", 256'(bus.stall), 256'(1'b1));
    serve_read("t6", 32'h00010000, line3, waits);
    check("t6_no_wb_after_rst", 256'(waits), 256'(0));
    @(negedge sys_clk);
    check("t6_refill_data", 256'(bus.l1_data_o), 256'(32'h30000000));

    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
